top: RTL and testbench

- Board-level LED heartbeat block for the 100 MHz FPGA board. Divides CLK100MHZ down to a human-visible blink on the single LED output.
- A prescaler produces a one-cycle phase tick, and an 8-phase sequencer turns that tick into either a square blink or a double-pulse "heartbeat" pattern.
- It is the top-level module of the design; only the board clock, reset and LED reach the pins.

---
 rtl/led_pkg.sv | 19 +
 rtl/led_if.sv | 9 +
 rtl/tick_prescaler.sv | 23 ++
 rtl/top.sv | 50 +++++
 tb/tb_top.sv | 102 ++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared constants and the phase-to-LED pattern lookup for the heartbeat block.
package led_pkg;

  localparam int unsigned MODE_SQUARE    = 0;
  localparam int unsigned MODE_HEARTBEAT = 1;
  localparam int unsigned PHASES         = 8;
  localparam int unsigned PHASE_W        = $clog2(PHASES);

  typedef logic [PHASE_W-1:0] phase_t;

  // Square: upper half of the period lit. Heartbeat: two short pulses at phases 4 and 6.
  function automatic logic pattern(input int unsigned mode, input phase_t p);
    logic lit;
    if (mode == MODE_HEARTBEAT) lit = (p == phase_t'(4)) || (p == phase_t'(6));
    else                        lit = p[PHASE_W-1];
    return lit;
  endfunction

endpackage

// File: rtl/led_if.sv
// Phase-tick strobe from the prescaler to the phase sequencer.
interface led_if;

  logic tick_c;

  modport master (output tick_c);
  modport slave  (input  tick_c);

endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every DIVIDE clocks, on the terminal count.
module tick_prescaler #(
  parameter int unsigned DIVIDE = 12_500_000
) (
  input  logic   clk,
  input  logic   rst,
  led_if.master  tick
);

  localparam int unsigned   CW   = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVIDE - 1);

  logic [CW-1:0] count;

  assign tick.tick_c = (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              count <= '0;
    else if (tick.tick_c) count <= '0;
    else                  count <= count + CW'(1);
  end

endmodule

// File: rtl/top.sv
// Board LED heartbeat: prescaled phase tick drives an 8-phase square or double-pulse pattern.
module top
  import led_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BLINK_HZ    = 1,
  parameter int unsigned MODE        = MODE_SQUARE
) (
  input  logic CLK100MHZ,
  input  logic RST,
  output logic LED
);

  localparam int unsigned PHASE_CYCLES = CLK_FREQ_HZ / (PHASES * BLINK_HZ);

  if (PHASE_CYCLES < 1) begin : g_bad_rate
    $error("top: CLK_FREQ_HZ (%0d) must be at least 8*BLINK_HZ (%0d)", CLK_FREQ_HZ, PHASES * BLINK_HZ);
  end

  if (MODE != MODE_SQUARE && MODE != MODE_HEARTBEAT) begin : g_bad_mode
    $error("top: MODE must be 0 (square) or 1 (heartbeat), got %0d", MODE);
  end

  led_if tick_if ();

  tick_prescaler #(
    .DIVIDE (PHASE_CYCLES)
  ) u_prescaler (
    .clk  (CLK100MHZ),
    .rst  (RST),
    .tick (tick_if.master)
  );

  phase_t phase;
  phase_t phase_nxt;

  assign phase_nxt = phase + phase_t'(1);

  // LED looks up the phase being entered so both change on the same tick edge.
  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      phase <= '0;
      LED   <= 1'b0;
    end else if (tick_if.tick_c) begin
      phase <= phase_nxt;
      LED   <= pattern(MODE, phase_nxt);
    end
  end

endmodule

// File: tb/tb_top.sv
// Randomized-reset bench for top: four parameterisations checked against an edge-count model.
module tb_top;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic led_sq;
  logic led_hb;
  logic led_fast;
  logic led_def;

  int checks = 0;
  int errors = 0;
  int unsigned k = 0;

  always #5 clk = ~clk;

  top #(.CLK_FREQ_HZ(800), .BLINK_HZ(1), .MODE(0)) dut_sq (
    .CLK100MHZ (clk), .RST (rst), .LED (led_sq));

  top #(.CLK_FREQ_HZ(800), .BLINK_HZ(1), .MODE(1)) dut_hb (
    .CLK100MHZ (clk), .RST (rst), .LED (led_hb));

  top #(.CLK_FREQ_HZ(8), .BLINK_HZ(1), .MODE(0)) dut_fast (
    .CLK100MHZ (clk), .RST (rst), .LED (led_fast));

  top dut_def (
    .CLK100MHZ (clk), .RST (rst), .LED (led_def));

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Expected LED after k edges since reset release, from the period/phase rules directly.
  function automatic logic ref_led(input int unsigned p_cycles, input int unsigned mode,
                                   input int unsigned edges);
    int unsigned ph;
    ph = (edges / p_cycles) % 8;
    if (mode == 1) return (ph == 4) || (ph == 6);
    return ph >= 4;
  endfunction

  task automatic check_all();
    check($sformatf("square k=%0d", k),    led_sq,   ref_led(100, 0, k));
    check($sformatf("heartbeat k=%0d", k), led_hb,   ref_led(100, 1, k));
    check($sformatf("fast k=%0d", k),      led_fast, ref_led(1, 0, k));
    check($sformatf("default k=%0d", k),   led_def,  ref_led(12_500_000, 0, k));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) k = 0;
    else     k++;
    #1;
    check_all();
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  // Reset asserted between edges must clear every LED before the next edge.
  task automatic async_reset(input int unsigned offset, input int unsigned hold);
    #(offset);
    rst = 1'b1;
    k   = 0;
    #1;
    check_all();
    run(hold);
    #(offset);
    rst = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 check_all();
    run(3);
    #2 rst = 1'b0;

    // Two full periods from release: rise at 400, fall at 800, rise at 1200.
    run(1700);
    async_reset(3, 2);

    // Reset at edge 450 while the square LED is lit, then the rise 400 edges after release.
    run(450);
    check("square lit at 450", led_sq, 1'b1);
    async_reset(2, 3);
    run(500);

    for (int s = 0; s < 6; s++) begin
      async_reset($urandom_range(1, 3), $urandom_range(1, 4));
      run($urandom_range(20, 1800));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
